// File: rtl/my_struct_package.sv
// Shared types for the L1 -> L2 message path: line state, L2 opcodes,
// message payload, command codes and the event-to-message planning rule.
package my_struct_package;

    typedef enum logic [1:0] {MESI_I, MESI_S, MESI_E, MESI_M} mesi_t;

    typedef enum logic [2:0] {READ, WRITE, RFO, INVALIDATE, RETURN} l2_op_t;

    typedef struct packed {
        l2_op_t      op;
        logic [31:0] addr;
    } l2_msg_t;

    // What one accepted event owes the L2: an optional victim write-back
    // followed by an optional main message.
    typedef struct packed {
        logic   need_wb;
        logic   need_main;
        l2_op_t op;
    } msg_plan_t;

    localparam logic [3:0] CMD_RD_DATA  = 4'd0;
    localparam logic [3:0] CMD_WR_DATA  = 4'd1;
    localparam logic [3:0] CMD_RD_INSTR = 4'd2;
    localparam logic [3:0] CMD_L2_INVAL = 4'd3;
    localparam logic [3:0] CMD_L2_SNOOP = 4'd4;
    localparam logic [3:0] CMD_CLEAR    = 4'd8;

    function automatic msg_plan_t plan_msgs(input logic [3:0] n, input logic hit,
                                            input mesi_t mesi, input logic victim_dirty);
        msg_plan_t p;
        p = '{need_wb: 1'b0, need_main: 1'b0, op: READ};
        case (n)
            CMD_RD_DATA, CMD_RD_INSTR: begin
                if (!hit) begin
                    p.need_wb   = victim_dirty;
                    p.need_main = 1'b1;
                    p.op        = READ;
                end
            end
            CMD_WR_DATA: begin
                if (!hit) begin
                    p.need_wb   = victim_dirty;
                    p.need_main = 1'b1;
                    p.op        = RFO;
                end else if (mesi == MESI_S) begin
                    p.need_main = 1'b1;
                    p.op        = INVALIDATE;
                end
            end
            CMD_L2_INVAL, CMD_L2_SNOOP: begin
                // Only a modified line owes its data back to the L2.
                if (mesi == MESI_M) begin
                    p.need_main = 1'b1;
                    p.op        = RETURN;
                end
            end
            default: ;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/l2_msg_fifo.sv
// Message FIFO for l2_msg_gen: power-of-two DEPTH, push/pop/flush,
// head shows READ/0 while empty so the bus idles at a known value.
module l2_msg_fifo
    import my_struct_package::*;
#(
    parameter int DEPTH = 8
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  l2_msg_t push_data,
    input  logic    pop,
    input  logic    flush,
    output l2_msg_t head,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    l2_msg_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? l2_msg_t'('0) : mem[rd_ptr];

    // NOTE: storage has no reset; the head is masked while empty, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/l2_msg_gen.sv
// l2_msg_gen: turns L1 command outcomes into the ordered L2 message stream.
// Statistics counters are built only when L2_MSG_STATS_EN is defined.
module l2_msg_gen
    import my_struct_package::*;
#(
    parameter int DEPTH = 8
`ifdef L2_MSG_STATS_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        evt_valid,
    output logic        evt_ready,
    input  logic [3:0]  evt_n,
    input  logic [31:0] evt_addr,
    input  logic        evt_hit,
    input  mesi_t       evt_mesi,
    input  logic        evt_victim_dirty,
    input  logic [31:0] evt_victim_addr,
    output logic        msg_valid,
    input  logic        msg_ready,
    output l2_op_t      msg_op,
    output logic [31:0] msg_addr
`ifdef L2_MSG_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_reads,
    output logic [CNT_W-1:0] stat_writes,
    output logic [CNT_W-1:0] stat_hits,
    output logic [CNT_W-1:0] stat_misses
`endif
);

    typedef enum logic [1:0] {IDLE, EMIT_WB, EMIT_MAIN} state_t;

    state_t      state;
    state_t      state_nx;
    msg_plan_t   plan;
    l2_op_t      lat_op;
    logic [31:0] lat_addr;
    logic [31:0] lat_wb_addr;
    logic        accept;
    logic        clear;
    logic        push;
    l2_msg_t     push_data;
    l2_msg_t     head;
    logic        fifo_full;
    logic        fifo_empty;

    assign plan      = plan_msgs(evt_n, evt_hit, evt_mesi, evt_victim_dirty);
    // Gated by rst so the producer sees no room while reset is held.
    assign evt_ready = rst && (state == IDLE) && !fifo_full;
    assign accept    = evt_valid && evt_ready;
    assign clear     = accept && (evt_n == CMD_CLEAR);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx  = state;
        push      = 1'b0;
        push_data = '{op: lat_op, addr: lat_addr};
        case (state)
            IDLE: begin
                if (accept) begin
                    if (plan.need_wb)        state_nx = EMIT_WB;
                    else if (plan.need_main) state_nx = EMIT_MAIN;
                end
            end
            EMIT_WB: begin
                push_data = '{op: WRITE, addr: lat_wb_addr};
                if (!fifo_full) begin
                    push     = 1'b1;
                    state_nx = EMIT_MAIN;
                end
            end
            EMIT_MAIN: begin
                if (!fifo_full) begin
                    push     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            lat_op      <= READ;
            lat_addr    <= '0;
            lat_wb_addr <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                lat_op      <= plan.op;
                lat_addr    <= evt_addr;
                lat_wb_addr <= evt_victim_addr;
            end
        end
    end

    l2_msg_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (msg_ready),
        .flush     (clear),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign msg_valid = !fifo_empty;
    assign msg_op    = head.op;
    assign msg_addr  = head.addr;

`ifdef L2_MSG_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_reads  <= '0;
            stat_writes <= '0;
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (clear) begin
            stat_reads  <= '0;
            stat_writes <= '0;
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (accept) begin
            if ((evt_n == CMD_RD_DATA || evt_n == CMD_RD_INSTR || evt_n == CMD_L2_SNOOP)
                && stat_reads != CNT_MAX)
                stat_reads <= stat_reads + 1'b1;
            if ((evt_n == CMD_WR_DATA || evt_n == CMD_L2_INVAL) && stat_writes != CNT_MAX)
                stat_writes <= stat_writes + 1'b1;
            if (evt_n <= CMD_L2_SNOOP) begin
                if (evt_hit && stat_hits != CNT_MAX)     stat_hits   <= stat_hits + 1'b1;
                if (!evt_hit && stat_misses != CNT_MAX)  stat_misses <= stat_misses + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_l2_msg_gen.sv
// Self-checking bench for l2_msg_gen: queue-based reference of the owed
// L2 messages plus directed scenarios; stats checked when L2_MSG_STATS_EN is set.
module tb_l2_msg_gen;
    import my_struct_package::*;

    localparam int DEPTH = 8;

    typedef struct {
        logic [3:0] n;
        logic       hit;
        mesi_t      mesi;
        logic       vd;
    } evt_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        evt_valid = 1'b0;
    logic [3:0]  evt_n = '0;
    logic [31:0] evt_addr = '0;
    logic        evt_hit = 1'b0;
    mesi_t       evt_mesi = MESI_I;
    logic        evt_victim_dirty = 1'b0;
    logic [31:0] evt_victim_addr = '0;
    logic        msg_ready = 1'b0;
    logic        evt_ready;
    logic        msg_valid;
    l2_op_t      msg_op;
    logic [31:0] msg_addr;
`ifdef L2_MSG_STATS_EN
    logic [31:0] stat_reads, stat_writes, stat_hits, stat_misses;
`endif

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          rand_ready = 1'b0;
    l2_msg_t     exp_q[$];
    logic [31:0] m_reads = '0, m_writes = '0, m_hits = '0, m_misses = '0;
    l2_msg_t     mon_e;
    l2_msg_t     hold_msg;
    bit          hold_vld = 1'b0;

    evt_t map_tab [0:11] = '{
        '{4'd1, 1'b1, MESI_S, 1'b0},  // INVALIDATE
        '{4'd1, 1'b1, MESI_M, 1'b0},  // none
        '{4'd4, 1'b0, MESI_M, 1'b0},  // RETURN
        '{4'd3, 1'b0, MESI_S, 1'b0},  // none
        '{4'd1, 1'b1, MESI_E, 1'b1},  // none, victim ignored on hit
        '{4'd0, 1'b1, MESI_S, 1'b1},  // none
        '{4'd2, 1'b0, MESI_I, 1'b1},  // WRITE victim, READ
        '{4'd3, 1'b0, MESI_M, 1'b1},  // RETURN only
        '{4'd4, 1'b1, MESI_S, 1'b0},  // none
        '{4'd9, 1'b0, MESI_I, 1'b1},  // none
        '{4'd5, 1'b0, MESI_M, 1'b1},  // none
        '{4'd2, 1'b1, MESI_E, 1'b0}   // none
    };

    l2_msg_gen #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .evt_valid        (evt_valid),
        .evt_ready        (evt_ready),
        .evt_n            (evt_n),
        .evt_addr         (evt_addr),
        .evt_hit          (evt_hit),
        .evt_mesi         (evt_mesi),
        .evt_victim_dirty (evt_victim_dirty),
        .evt_victim_addr  (evt_victim_addr),
        .msg_valid        (msg_valid),
        .msg_ready        (msg_ready),
        .msg_op           (msg_op),
        .msg_addr         (msg_addr)
`ifdef L2_MSG_STATS_EN
        ,
        .stat_reads       (stat_reads),
        .stat_writes      (stat_writes),
        .stat_hits        (stat_hits),
        .stat_misses      (stat_misses)
`endif
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) msg_ready = 1'($urandom_range(0, 1));
    end

    // Consumer-side monitor: each pop must match the oldest owed message,
    // and a stalled head must not change.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            hold_vld = 1'b0;
        end else begin
            if (hold_vld && msg_valid) begin
                checks++;
                if (msg_op !== hold_msg.op || msg_addr !== hold_msg.addr) begin
                    errors++;
                    $display("FAIL stable_head: got op=%0d addr=%h, held op=%0d addr=%h",
                             msg_op, msg_addr, hold_msg.op, hold_msg.addr);
                end
            end
            if (msg_valid && msg_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_msg: got op=%0d addr=%h, expected no message",
                             msg_op, msg_addr);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (msg_op !== mon_e.op || msg_addr !== mon_e.addr) begin
                        errors++;
                        $display("FAIL msg_order: got op=%0d addr=%h, expected op=%0d addr=%h",
                                 msg_op, msg_addr, mon_e.op, mon_e.addr);
                    end
                end
                hold_vld = 1'b0;
            end else if (msg_valid) begin
                hold_vld = 1'b1;
                hold_msg = '{op: msg_op, addr: msg_addr};
            end else begin
                hold_vld = 1'b0;
            end
        end
    end

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Reference: what the L1 owes the L2 for one accepted event.
    task automatic model_event(input logic [3:0] n, input logic [31:0] addr, input logic hit,
                               input mesi_t mesi, input logic vd, input logic [31:0] va);
        case (n)
            4'd0, 4'd2: if (!hit) begin
                if (vd) exp_q.push_back('{op: WRITE, addr: va});
                exp_q.push_back('{op: READ, addr: addr});
            end
            4'd1: if (!hit) begin
                if (vd) exp_q.push_back('{op: WRITE, addr: va});
                exp_q.push_back('{op: RFO, addr: addr});
            end else if (mesi == MESI_S) begin
                exp_q.push_back('{op: INVALIDATE, addr: addr});
            end
            4'd3, 4'd4: if (mesi == MESI_M) exp_q.push_back('{op: RETURN, addr: addr});
            4'd8: exp_q.delete();
            default: ;
        endcase
        if (n == 4'd8) begin
            m_reads = '0; m_writes = '0; m_hits = '0; m_misses = '0;
        end
        if (n == 4'd0 || n == 4'd2 || n == 4'd4) m_reads = sat_inc(m_reads);
        if (n == 4'd1 || n == 4'd3) m_writes = sat_inc(m_writes);
        if (n <= 4'd4) begin
            if (hit) m_hits = sat_inc(m_hits);
            else     m_misses = sat_inc(m_misses);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_event(input logic [3:0] n, input logic [31:0] addr, input logic hit,
                              input mesi_t mesi, input logic vd, input logic [31:0] va,
                              input int budget);
        bit ok = 1'b0;
        evt_n = n; evt_addr = addr; evt_hit = hit; evt_mesi = mesi;
        evt_victim_dirty = vd; evt_victim_addr = va; evt_valid = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (evt_ready) begin
                @(posedge clk);
                model_event(n, addr, hit, mesi, vd, va);
                ok = 1'b1;
                break;
            end
            @(posedge clk);
        end
        #1;
        evt_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout: event n=%0d not accepted within %0d cycles", n, budget);
        end
    endtask

    task automatic drain();
        rand_ready = 1'b0;
        msg_ready  = 1'b1;
        for (int i = 0; i < 200 && (exp_q.size() != 0 || msg_valid); i++) begin
            @(posedge clk);
            #1;
        end
        msg_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0 || msg_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain: %0d owed messages left, msg_valid=%b, required 0 and 0",
                     exp_q.size(), msg_valid);
        end
    endtask

    task automatic check_stats(input string tag);
`ifdef L2_MSG_STATS_EN
        checks++;
        if (stat_reads !== m_reads || stat_writes !== m_writes ||
            stat_hits !== m_hits || stat_misses !== m_misses) begin
            errors++;
            $display("FAIL stats_%s: got r=%0d w=%0d h=%0d m=%0d, expected r=%0d w=%0d h=%0d m=%0d",
                     tag, stat_reads, stat_writes, stat_hits, stat_misses,
                     m_reads, m_writes, m_hits, m_misses);
        end
`else
        if (tag.len() == 0) $display("stats check skipped");
`endif
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if (evt_ready !== 1'b0 || msg_valid !== 1'b0 || msg_op !== READ || msg_addr !== 32'h0) begin
            errors++;
            $display("FAIL %s: got ready=%b valid=%b op=%0d addr=%h, expected 0 0 0 00000000",
                     tag, evt_ready, msg_valid, msg_op, msg_addr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset_values");
        check_stats("reset");
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (evt_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b expected 1", evt_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_read();
        msg_ready = 1'b0;
        send_event(4'd0, 32'h984D_E132, 1'b0, MESI_I, 1'b0, $urandom, 10);
        checks++;
        if (msg_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_latency_e0: msg_valid=%b expected 0", msg_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (msg_valid !== 1'b1 || msg_op !== READ || msg_addr !== 32'h984D_E132) begin
            errors++;
            $display("FAIL read_latency_e1: got valid=%b op=%0d addr=%h expected 1 0 984de132",
                     msg_valid, msg_op, msg_addr);
        end
        drain();
    endtask

    task automatic test_writeback();
        logic [31:0] a = $urandom;
        msg_ready = 1'b0;
        send_event(4'd1, a, 1'b0, MESI_I, 1'b1, 32'h116D_E100, 10);
        checks++;
        if (evt_ready !== 1'b0 || msg_valid !== 1'b0) begin
            errors++;
            $display("FAIL wb_e0: got ready=%b valid=%b expected 0 0", evt_ready, msg_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (evt_ready !== 1'b0 || msg_valid !== 1'b1 || msg_op !== WRITE || msg_addr !== 32'h116D_E100) begin
            errors++;
            $display("FAIL wb_e1: got ready=%b valid=%b op=%0d addr=%h expected 0 1 1 116de100",
                     evt_ready, msg_valid, msg_op, msg_addr);
        end
        @(posedge clk);
        #1;
        checks++;
        if (evt_ready !== 1'b1) begin
            errors++;
            $display("FAIL wb_e2_ready: got %b expected 1", evt_ready);
        end
        drain();
    endtask

    task automatic test_mapping();
        rand_ready = 1'b1;
        foreach (map_tab[i])
            send_event(map_tab[i].n, $urandom, map_tab[i].hit, map_tab[i].mesi,
                       map_tab[i].vd, $urandom, 50);
        drain();
        check_stats("mapping");
    endtask

    task automatic test_back_to_back();
        int last;
        msg_ready = 1'b1;
        send_event(4'd0, $urandom, 1'b0, MESI_I, 1'b0, '0, 10);
        last = cyc;
        for (int i = 0; i < 4; i++) begin
            send_event(4'd2, $urandom, 1'b0, MESI_I, 1'b0, '0, 10);
            checks++;
            if (cyc - last != 2) begin
                errors++;
                $display("FAIL throughput: accept spacing %0d cycles, expected 2", cyc - last);
            end
            last = cyc;
        end
        drain();
    endtask

    task automatic test_full();
        msg_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            send_event(4'd0, $urandom, 1'b0, MESI_I, 1'b0, '0, 10);
        @(posedge clk);
        #1;
        checks++;
        if (evt_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready: got %b expected 0 with %0d entries", evt_ready, DEPTH);
        end
        evt_n = 4'd1; evt_addr = 32'hCAFE_0040; evt_hit = 1'b0; evt_mesi = MESI_I;
        evt_victim_dirty = 1'b0; evt_victim_addr = '0; evt_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (evt_ready !== 1'b0) begin
                errors++;
                $display("FAIL full_hold: ready=%b while full, expected 0", evt_ready);
            end
            @(posedge clk);
            #1;
        end
        msg_ready = 1'b1;
        @(posedge clk);
        #1;
        msg_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (evt_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_release: ready=%b after one pop, expected 1", evt_ready);
        end
        @(posedge clk);
        model_event(4'd1, 32'hCAFE_0040, 1'b0, MESI_I, 1'b0, '0);
        #1;
        evt_valid = 1'b0;
        drain();
    endtask

    task automatic test_random();
        logic [3:0] codes [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9, 4'd6};
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++)
            send_event(codes[$urandom_range(0, 7)], $urandom, 1'($urandom_range(0, 1)),
                       mesi_t'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, 100);
        drain();
        check_stats("random");
    endtask

    task automatic test_flush();
        msg_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send_event(4'd1, $urandom, 1'b0, MESI_I, 1'b0, '0, 10);
        @(posedge clk);
        #1;
        checks++;
        if (msg_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre: msg_valid=%b expected 1", msg_valid);
        end
        msg_ready = 1'b1;
        send_event(4'd8, $urandom, 1'b0, MESI_I, 1'b0, '0, 10);
        msg_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (msg_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_valid: msg_valid=%b after clear, expected 0", msg_valid);
        end
        check_stats("flush");
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        msg_ready = 1'b0;
        send_event(4'd1, $urandom, 1'b0, MESI_I, 1'b1, 32'h0BAD_0000 | $urandom_range(0, 255), 10);
        #1;
        rst = 1'b0;
        #1;
        exp_q.delete();
        m_reads = '0; m_writes = '0; m_hits = '0; m_misses = '0;
        check_idle_outputs("reset_mid");
        check_stats("reset_mid");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        msg_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (msg_valid) seen = 1'b1;
        end
        @(posedge clk);
        #1;
        msg_ready = 1'b0;
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_discard: message appeared after reset release, expected none");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_read();
        test_writeback();
        test_mapping();
        test_back_to_back();
        test_full();
        test_random();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
